hdmi_hmode_lockctl: RTL and testbench

// - Sequences horizontal-mode acquisition for the HDMI receive path.
// - Samples the measured horizontal mode (npix, sstart, ssend, htotal) once per frame and qualifies it.
// - Declares lock after a run of identical, sane frames. Drops lock after a run of bad frames or loss of frame strobes.
// - Drives the locked mode into the downstream video pipeline, and raises strobes for the bus interrupt logic.

---
 rtl/hdmi_hmode_lockctl.sv | 175 +++++++++++++++++
 tb/tb_hdmi_hmode_lockctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_hmode_lockctl.sv
// Horizontal-mode lock controller for the HDMI receive path.
// Samples the measured line timing once per frame (vsync rising edge),
// qualifies it over a run of identical sane frames, holds lock until a run
// of bad frames or a frame-strobe timeout, and supports a software-forced mode.
module hdmi_hmode_lockctl #(
  parameter logic [3:0] LOCK_FRAMES   = 4'd4,
  parameter logic [3:0] UNLOCK_FRAMES = 4'd2,
  parameter logic [4:0] TIMEOUT_LG    = 5'd24
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_vsync,
  input  logic [15:0] i_npix,
  input  logic [15:0] i_sstart,
  input  logic [15:0] i_ssend,
  input  logic [15:0] i_htotal,
  input  logic        i_force,
  input  logic [63:0] i_force_mode,
  output logic [63:0] o_mode,
  output logic        o_locked,
  output logic        o_new_mode,
  output logic        o_lost,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_QUALIFY = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_FORCED  = 2'b11
  } state_t;

  // Watchdog is one bit wider than the timeout exponent; the top bit is the flag.
  localparam int            TW     = int'(TIMEOUT_LG) + 1;
  localparam logic [TW-1:0] WD_ONE = TW'(1);

  state_t        state, nstate;
  logic          vsync_d;
  logic          fs;
  logic [63:0]   s_cur;
  logic [63:0]   last_s;
  logic          sane, match, bad, timeout;
  logic [TW-1:0] wd;
  logic [3:0]    run, bad_run, run_inc, bad_inc;
  logic [3:0]    run_nx, bad_nx;
  logic [63:0]   mode_nx;
  logic          newm_nx, lost_nx;

  assign fs      = i_vsync & ~vsync_d;
  assign s_cur   = {i_npix, i_sstart, i_ssend, i_htotal};
  assign sane    = (i_npix != 16'd0) && (i_npix < i_sstart) &&
                   (i_sstart < i_ssend) && (i_ssend <= i_htotal);
  assign match   = sane && (s_cur == last_s);
  assign bad     = !sane || (s_cur != o_mode);
  assign timeout = wd[TW-1];
  assign run_inc = (run == 4'hF) ? run : run + 4'd1;
  assign bad_inc = (bad_run == 4'hF) ? bad_run : bad_run + 4'd1;
  assign o_state = state;

  // Frame-strobe edge detect, last-sample capture and watchdog.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vsync_d <= 1'b0;
      last_s  <= '0;
      wd      <= '0;
    end else begin
      vsync_d <= i_vsync;
      if (fs) last_s <= s_cur;
      if (fs)           wd <= '0;
      else if (!timeout) wd <= wd + WD_ONE;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_SEARCH;
    else            state <= nstate;
  end

  // Next-state decode; force overrides frame strobes and timeouts.
  always_comb begin
    nstate = state;
    if (i_force) begin
      nstate = ST_FORCED;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (fs && sane)
            nstate = (LOCK_FRAMES <= 4'd1) ? ST_LOCKED : ST_QUALIFY;
        end
        ST_QUALIFY: begin
          if (timeout)
            nstate = ST_SEARCH;
          else if (fs) begin
            if (match) begin
              if (run_inc >= LOCK_FRAMES) nstate = ST_LOCKED;
            end else if (!sane) begin
              nstate = ST_SEARCH;
            end
          end
        end
        ST_LOCKED: begin
          if (timeout)
            nstate = ST_SEARCH;
          else if (fs && bad && (bad_inc >= UNLOCK_FRAMES))
            nstate = ST_SEARCH;
        end
        default: nstate = ST_SEARCH;  // FORCED with force released
      endcase
    end
  end

  // Output/counter next values, keyed off the current and next state.
  always_comb begin
    run_nx  = run;
    bad_nx  = bad_run;
    mode_nx = o_mode;
    newm_nx = 1'b0;
    lost_nx = 1'b0;
    if (i_force) begin
      run_nx  = 4'd0;
      bad_nx  = 4'd0;
      mode_nx = i_force_mode;
      newm_nx = (state != ST_FORCED) || (i_force_mode != o_mode);
    end else begin
      case (state)
        ST_SEARCH: begin
          if (fs && sane) run_nx = 4'd1;
        end
        ST_QUALIFY: begin
          if (nstate == ST_SEARCH)  run_nx = 4'd0;
          else if (fs)              run_nx = match ? run_inc : 4'd1;
        end
        ST_LOCKED: begin
          if (fs) bad_nx = bad ? bad_inc : 4'd0;
          if (nstate == ST_SEARCH) begin
            lost_nx = 1'b1;
            bad_nx  = 4'd0;
            run_nx  = 4'd0;
          end
        end
        default: begin
          run_nx = 4'd0;
          bad_nx = 4'd0;
        end
      endcase
      // Any fresh entry into LOCKED latches the sample that completed the run.
      if (nstate == ST_LOCKED && state != ST_LOCKED) begin
        mode_nx = s_cur;
        newm_nx = 1'b1;
        bad_nx  = 4'd0;
      end
    end
  end

  // Registered outputs and run counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run        <= 4'd0;
      bad_run    <= 4'd0;
      o_mode     <= '0;
      o_new_mode <= 1'b0;
      o_lost     <= 1'b0;
      o_locked   <= 1'b0;
    end else begin
      run        <= run_nx;
      bad_run    <= bad_nx;
      o_mode     <= mode_nx;
      o_new_mode <= newm_nx;
      o_lost     <= lost_nx;
      o_locked   <= (nstate == ST_LOCKED) || (nstate == ST_FORCED);
    end
  end

endmodule

// File: tb/tb_hdmi_hmode_lockctl.sv
// Directed bench for hdmi_hmode_lockctl: lock, unlock, insane frame,
// watchdog timeout, software force and mid-run reset.
module tb_hdmi_hmode_lockctl;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_vsync = 1'b0;
  logic [15:0] i_npix = '0, i_sstart = '0, i_ssend = '0, i_htotal = '0;
  logic        i_force = 1'b0;
  logic [63:0] i_force_mode = '0;
  logic [63:0] o_mode;
  logic        o_locked, o_new_mode, o_lost;
  logic [1:0]  o_state;

  localparam logic [63:0] M720  = 64'h0500_056E_0596_0672; // 1280,1390,1430,1650
  localparam logic [63:0] F720  = 64'h0500_06B8_06E0_07BC; // 1280,1720,1760,1980
  localparam logic [63:0] F1080 = 64'h0780_07D8_0804_0898; // 1920,2008,2052,2200

  int n_cmp = 0;
  int n_bad = 0;
  int nm_cnt = 0;
  int lost_cnt = 0;

  hdmi_hmode_lockctl #(
    .LOCK_FRAMES(4'd4), .UNLOCK_FRAMES(4'd2), .TIMEOUT_LG(5'd8)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_vsync(i_vsync),
    .i_npix(i_npix), .i_sstart(i_sstart), .i_ssend(i_ssend), .i_htotal(i_htotal),
    .i_force(i_force), .i_force_mode(i_force_mode),
    .o_mode(o_mode), .o_locked(o_locked), .o_new_mode(o_new_mode),
    .o_lost(o_lost), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Pulse tallies, read as differences by the tests.
  always @(negedge i_clk) begin
    if (o_new_mode === 1'b1) nm_cnt++;
    if (o_lost === 1'b1) lost_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // One frame: vsync high for one cycle, then three idle cycles.
  task automatic frame(input logic [15:0] np, ss, se, ht);
    @(negedge i_clk);
    i_npix = np; i_sstart = ss; i_ssend = se; i_htotal = ht; i_vsync = 1'b1;
    @(negedge i_clk);
    i_vsync = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (o_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", o_state); end
    n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    n_cmp++; if (o_mode !== 64'd0) begin n_bad++; $display("FAIL reset_mode: got %h want 0", o_mode); end
    n_cmp++; if (o_new_mode !== 1'b0 || o_lost !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got new=%b lost=%b want 0 0", o_new_mode, o_lost); end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_lock;
    int nm0;
    nm0 = nm_cnt;
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b01) begin n_bad++; $display("FAIL lock_f1_state: got %b want 01", o_state); end
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b01 || o_locked !== 1'b0) begin n_bad++; $display("FAIL lock_f3: got state=%b locked=%b want 01 0", o_state, o_locked); end
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b10) begin n_bad++; $display("FAIL lock_f4_state: got %b want 10", o_state); end
    n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL lock_f4_locked: got %b want 1", o_locked); end
    n_cmp++; if (o_mode !== M720) begin n_bad++; $display("FAIL lock_mode: got %h want %h", o_mode, M720); end
    n_cmp++; if (nm_cnt - nm0 != 1) begin n_bad++; $display("FAIL lock_new_mode_count: got %0d want 1", nm_cnt - nm0); end
  endtask

  task automatic test_unlock;
    int l0;
    l0 = lost_cnt;
    frame(1280, 1390, 1430, 1651);
    n_cmp++; if (o_state !== 2'b10) begin n_bad++; $display("FAIL unlock_glitch_state: got %b want 10", o_state); end
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1651);
    n_cmp++; if (o_state !== 2'b10 || lost_cnt - l0 != 0) begin n_bad++; $display("FAIL unlock_single_bad: got state=%b lost=%0d want 10 0", o_state, lost_cnt - l0); end
    frame(1280, 1390, 1430, 1651);
    n_cmp++; if (o_state !== 2'b00 || o_locked !== 1'b0) begin n_bad++; $display("FAIL unlock_state: got state=%b locked=%b want 00 0", o_state, o_locked); end
    n_cmp++; if (lost_cnt - l0 != 1) begin n_bad++; $display("FAIL unlock_lost_count: got %0d want 1", lost_cnt - l0); end
    n_cmp++; if (o_mode !== M720) begin n_bad++; $display("FAIL unlock_mode_hold: got %h want %h", o_mode, M720); end
  endtask

  task automatic test_insane;
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1200, 1430, 1650);
    n_cmp++; if (o_state !== 2'b00 || o_locked !== 1'b0) begin n_bad++; $display("FAIL insane_state: got state=%b locked=%b want 00 0", o_state, o_locked); end
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b01) begin n_bad++; $display("FAIL insane_requal3: got %b want 01", o_state); end
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b10) begin n_bad++; $display("FAIL insane_requal4: got %b want 10", o_state); end
  endtask

  task automatic test_timeout;
    int l0, at;
    bit found;
    l0 = lost_cnt; found = 0; at = 0;
    @(negedge i_clk);
    i_npix = 1280; i_sstart = 1390; i_ssend = 1430; i_htotal = 1650; i_vsync = 1'b1;
    @(negedge i_clk);
    i_vsync = 1'b0;
    for (int n = 1; n <= 400 && !found; n++) begin
      if (n > 1) @(negedge i_clk);
      if (o_lost === 1'b1) begin found = 1; at = n; end
    end
    n_cmp++; if (!found || at < 256 || at > 258) begin n_bad++; $display("FAIL timeout_lost_cycle: got found=%0d at=%0d want 256..258", found, at); end
    @(negedge i_clk);
    n_cmp++; if (o_state !== 2'b00 || o_locked !== 1'b0) begin n_bad++; $display("FAIL timeout_state: got state=%b locked=%b want 00 0", o_state, o_locked); end
    n_cmp++; if (lost_cnt - l0 != 1) begin n_bad++; $display("FAIL timeout_lost_count: got %0d want 1", lost_cnt - l0); end
  endtask

  task automatic test_force;
    int nm0, l0;
    nm0 = nm_cnt; l0 = lost_cnt;
    @(negedge i_clk);
    i_npix = 1280; i_sstart = 1390; i_ssend = 1430; i_htotal = 1650;
    i_vsync = 1'b1; i_force = 1'b1; i_force_mode = F720;
    @(negedge i_clk);
    i_vsync = 1'b0;
    n_cmp++; if (o_state !== 2'b11 || o_locked !== 1'b1) begin n_bad++; $display("FAIL force_state: got state=%b locked=%b want 11 1", o_state, o_locked); end
    n_cmp++; if (o_mode !== F720) begin n_bad++; $display("FAIL force_mode: got %h want %h", o_mode, F720); end
    repeat (4) @(negedge i_clk);
    n_cmp++; if (nm_cnt - nm0 != 1) begin n_bad++; $display("FAIL force_new_mode_once: got %0d want 1", nm_cnt - nm0); end
    i_force_mode = F1080;
    @(negedge i_clk);
    @(negedge i_clk);
    n_cmp++; if (o_mode !== F1080) begin n_bad++; $display("FAIL force_mode_change: got %h want %h", o_mode, F1080); end
    repeat (2) @(negedge i_clk);
    n_cmp++; if (nm_cnt - nm0 != 2) begin n_bad++; $display("FAIL force_change_pulse: got %0d want 2", nm_cnt - nm0); end
    i_force = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_state !== 2'b00 || o_locked !== 1'b0) begin n_bad++; $display("FAIL force_release_state: got state=%b locked=%b want 00 0", o_state, o_locked); end
    repeat (3) @(negedge i_clk);
    n_cmp++; if (lost_cnt - l0 != 0 || nm_cnt - nm0 != 2) begin n_bad++; $display("FAIL force_release_pulses: got lost=%0d new=%0d want 0 2", lost_cnt - l0, nm_cnt - nm0); end
    n_cmp++; if (o_mode !== F1080) begin n_bad++; $display("FAIL force_release_hold: got %h want %h", o_mode, F1080); end
  endtask

  task automatic test_reset_mid;
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b01) begin n_bad++; $display("FAIL rmid_pre_state: got %b want 01", o_state); end
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++; if (o_state !== 2'b00 || o_locked !== 1'b0) begin n_bad++; $display("FAIL rmid_async_state: got state=%b locked=%b want 00 0", o_state, o_locked); end
    n_cmp++; if (o_mode !== 64'd0 || o_new_mode !== 1'b0 || o_lost !== 1'b0) begin n_bad++; $display("FAIL rmid_async_outs: got mode=%h new=%b lost=%b want 0 0 0", o_mode, o_new_mode, o_lost); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b01 || o_locked !== 1'b0) begin n_bad++; $display("FAIL rmid_relock3: got state=%b locked=%b want 01 0", o_state, o_locked); end
    frame(1280, 1390, 1430, 1650);
    n_cmp++; if (o_state !== 2'b10 || o_mode !== M720) begin n_bad++; $display("FAIL rmid_relock4: got state=%b mode=%h want 10 %h", o_state, o_mode, M720); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_unlock;
    test_insane;
    test_timeout;
    test_force;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
